mem_slot_scheduler: RTL and testbench

Parametrised successor to the fixed four-cycle RAM/ROM bus interleaver. It generates the 8 MHz phase enables and the video / CPU / extra cycle pattern. The extra cycle is shared among NUM_EXT DMA clients (floppy images, audio, future SCSI/ethernet buffers) through a req/ack handshake: round-robin arbitration that skips idle clients, or a legacy fixed rotation. It drives the shared memory address mux and sits between the CPU address decoder and the SDRAM controller.

---
 rtl/mem_slot_scheduler.sv | 147 ++++++++++++++
 tb/tb_mem_slot_scheduler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_slot_scheduler.sv
// mem_slot_scheduler
// Generates the 8 MHz phase enables and the video / CPU / extra bus cycle
// pattern, and shares the extra cycle among NUM_EXT DMA clients through a
// req/ack handshake.
//
// Ports:
//   clk             system clock (4x CPU clock)
//   _reset          asynchronous active-low reset
//   cpuAddr         CPU address
//   videoAddr       video fetch address
//   ext_req         per-client level request, bit i = client i
//   ext_addr        packed client addresses, client i at [i*ADDR_W +: ADDR_W]
//   clk8_en_p/n     one-clk enables at busPhase 3 / 1
//   memoryLatch     high while busPhase == 3
//   busCycle        current bus cycle (0 video, 1/3 CPU, 2 extra)
//   *BusControl     cycle owner flags
//   ext_ack         one-hot grant, high for the whole granted extra cycle
//   ext_done        one-clk pulse on the latch clk of the granted extra cycle
//   ext_grant_idx   index of the current/last granted client
//   memoryAddr      muxed memory address
module mem_slot_scheduler #(
  parameter int ADDR_W         = 22,
  parameter int NUM_EXT        = 4,
  parameter int FIXED_ROTATION = 0
) (
  input  logic                      clk,
  input  logic                      _reset,
  input  logic [ADDR_W-1:0]         cpuAddr,
  input  logic [ADDR_W-1:0]         videoAddr,
  input  logic [NUM_EXT-1:0]        ext_req,
  input  logic [NUM_EXT*ADDR_W-1:0] ext_addr,
  output logic                      clk8_en_p,
  output logic                      clk8_en_n,
  output logic                      memoryLatch,
  output logic [1:0]                busCycle,
  output logic                      videoBusControl,
  output logic                      cpuBusControl,
  output logic                      extraBusControl,
  output logic [NUM_EXT-1:0]        ext_ack,
  output logic [NUM_EXT-1:0]        ext_done,
  output logic [2:0]                ext_grant_idx,
  output logic [ADDR_W-1:0]         memoryAddr
);

  logic [1:0]         r_busPhase;
  logic [1:0]         r_busCycle;
  logic               r_grantValid;
  logic [2:0]         r_grantIdx;
  logic [2:0]         r_lastIdx;
  logic [2:0]         r_rotCnt;

  logic               w_decide;
  logic               w_rrFound;
  logic [2:0]         w_rrIdx;
  logic [3:0]         w_cand;
  logic [2:0]         w_rotNext;
  logic [NUM_EXT-1:0] w_ack;

  // The arbitration decision is taken on the last clk of the first CPU cycle,
  // so the winner is stable for the whole following extra cycle.
  assign w_decide = (r_busCycle == 2'd1) && (r_busPhase == 2'd3);

  // Round-robin search: walk the clients starting just after the last
  // winner, wrapping modulo NUM_EXT (not modulo 8), first requester wins.
  // last+k stays below 2*NUM_EXT, so a single subtract performs the wrap.
  always_comb begin
    w_rrFound = 1'b0;
    w_rrIdx   = '0;
    w_cand    = '0;
    for (int k = 1; k <= NUM_EXT; k++) begin
      w_cand = {1'b0, r_lastIdx} + 4'(k);
      if (w_cand >= 4'(NUM_EXT)) begin
        w_cand = w_cand - 4'(NUM_EXT);
      end
      for (int j = 0; j < NUM_EXT; j++) begin
        if (!w_rrFound && (w_cand == 4'(j)) && ext_req[j]) begin
          w_rrFound = 1'b1;
          w_rrIdx   = 3'(j);
        end
      end
    end
  end

  assign w_rotNext = (r_rotCnt == 3'(NUM_EXT - 1)) ? 3'd0 : r_rotCnt + 3'd1;

  // Bus sequencer and grant registers. An idle round-robin window keeps
  // the last winner so fairness is not disturbed by empty slots.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      r_busPhase   <= 2'd0;
      r_busCycle   <= 2'd0;
      r_grantValid <= 1'b0;
      r_grantIdx   <= 3'd0;
      r_lastIdx    <= 3'(NUM_EXT - 1);
      r_rotCnt     <= 3'(NUM_EXT - 1);
    end else begin
      r_busPhase <= r_busPhase + 2'd1;
      if (r_busPhase == 2'd3) begin
        r_busCycle <= r_busCycle + 2'd1;
      end
      if (w_decide) begin
        if (FIXED_ROTATION != 0) begin
          r_rotCnt     <= w_rotNext;
          r_grantValid <= 1'b1;
          r_grantIdx   <= w_rotNext;
        end else begin
          r_grantValid <= w_rrFound;
          if (w_rrFound) begin
            r_grantIdx <= w_rrIdx;
            r_lastIdx  <= w_rrIdx;
          end
        end
      end
    end
  end

  assign busCycle        = r_busCycle;
  assign clk8_en_p       = (r_busPhase == 2'd3);
  assign clk8_en_n       = (r_busPhase == 2'd1);
  assign memoryLatch     = (r_busPhase == 2'd3);
  assign videoBusControl = (r_busCycle == 2'd0);
  assign cpuBusControl   = r_busCycle[0];
  assign extraBusControl = (r_busCycle == 2'd2);
  assign ext_grant_idx   = r_grantIdx;

  // One-hot acknowledge decoded from registered state only.
  always_comb begin
    w_ack = '0;
    for (int i = 0; i < NUM_EXT; i++) begin
      w_ack[i] = extraBusControl && r_grantValid && (r_grantIdx == 3'(i));
    end
  end

  assign ext_ack  = w_ack;
  assign ext_done = w_ack & {NUM_EXT{memoryLatch}};

  // Address mux: a granted DMA client beats video, video beats CPU.
  always_comb begin
    memoryAddr = videoBusControl ? videoAddr : cpuAddr;
    for (int i = 0; i < NUM_EXT; i++) begin
      if (w_ack[i]) begin
        memoryAddr = ext_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

endmodule

// File: tb/tb_mem_slot_scheduler.sv
// Testbench for mem_slot_scheduler: drives a round-robin instance and a
// fixed-rotation instance with the same stimulus and compares every output
// each clk against a timeline model of the bus schedule and arbitration.
module tb_mem_slot_scheduler;

  localparam int ADDR_W  = 22;
  localparam int NUM_EXT = 4;

  logic                      clk = 1'b0;
  logic                      rstN = 1'b0;
  logic [ADDR_W-1:0]         cpuAddr = '0;
  logic [ADDR_W-1:0]         videoAddr = '0;
  logic [NUM_EXT-1:0]        extReq = '0;
  logic [ADDR_W-1:0]         extAddrArr [NUM_EXT];
  logic [NUM_EXT*ADDR_W-1:0] extAddrBus;

  logic                      rrEnP, rrEnN, rrLatch, rrVideo, rrCpu, rrExtra;
  logic [1:0]                rrCycle;
  logic [NUM_EXT-1:0]        rrAck, rrDone;
  logic [2:0]                rrIdx;
  logic [ADDR_W-1:0]         rrAddr;

  logic                      fxEnP, fxEnN, fxLatch, fxVideo, fxCpu, fxExtra;
  logic [1:0]                fxCycle;
  logic [NUM_EXT-1:0]        fxAck, fxDone;
  logic [2:0]                fxIdx;
  logic [ADDR_W-1:0]         fxAddr;

  int checkCount = 0;
  int errorCount = 0;

  // Reference model: absolute clk count since reset plus arbitration state.
  int mT     = 0;
  int mValid = 0;
  int mIdx   = 0;
  int mLast  = NUM_EXT - 1;
  int fValid = 0;
  int fIdx   = 0;
  int fRot   = NUM_EXT - 1;

  int rrLog[$];
  int fxLog[$];
  logic [NUM_EXT-1:0] pending = '0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NUM_EXT; i++) begin
      extAddrBus[i*ADDR_W +: ADDR_W] = extAddrArr[i];
    end
  end

  mem_slot_scheduler #(.ADDR_W(ADDR_W), .NUM_EXT(NUM_EXT), .FIXED_ROTATION(0)) dutRr (
    .clk(clk), ._reset(rstN), .cpuAddr(cpuAddr), .videoAddr(videoAddr),
    .ext_req(extReq), .ext_addr(extAddrBus),
    .clk8_en_p(rrEnP), .clk8_en_n(rrEnN), .memoryLatch(rrLatch), .busCycle(rrCycle),
    .videoBusControl(rrVideo), .cpuBusControl(rrCpu), .extraBusControl(rrExtra),
    .ext_ack(rrAck), .ext_done(rrDone), .ext_grant_idx(rrIdx), .memoryAddr(rrAddr)
  );

  mem_slot_scheduler #(.ADDR_W(ADDR_W), .NUM_EXT(NUM_EXT), .FIXED_ROTATION(1)) dutFx (
    .clk(clk), ._reset(rstN), .cpuAddr(cpuAddr), .videoAddr(videoAddr),
    .ext_req(extReq), .ext_addr(extAddrBus),
    .clk8_en_p(fxEnP), .clk8_en_n(fxEnN), .memoryLatch(fxLatch), .busCycle(fxCycle),
    .videoBusControl(fxVideo), .cpuBusControl(fxCpu), .extraBusControl(fxExtra),
    .ext_ack(fxAck), .ext_done(fxDone), .ext_grant_idx(fxIdx), .memoryAddr(fxAddr)
  );

  // Model update: decisions happen at clk 7 of every 16-clk frame.
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mT = 0; mValid = 0; mIdx = 0; mLast = NUM_EXT - 1;
      fValid = 0; fIdx = 0; fRot = NUM_EXT - 1;
    end else begin
      if (mT % 16 == 7) begin
        int found;
        found = 0;
        for (int k = 1; k <= NUM_EXT; k++) begin
          int c;
          c = (mLast + k) % NUM_EXT;
          if (found == 0 && extReq[c]) begin
            found = 1;
            mIdx  = c;
            mLast = c;
          end
        end
        mValid = found;
        fRot   = (fRot + 1) % NUM_EXT;
        fIdx   = fRot;
        fValid = 1;
      end
      mT = mT + 1;
    end
  end

  function automatic logic [NUM_EXT-1:0] expAck(input int valid, input int idx);
    if (((mT / 4) % 4) == 2 && valid != 0) return NUM_EXT'(1) << idx;
    return '0;
  endfunction

  function automatic logic [ADDR_W-1:0] expAddr(input logic [NUM_EXT-1:0] ack, input int idx);
    if (ack != 0) return extAddrArr[idx];
    if (((mT / 4) % 4) == 0) return videoAddr;
    return cpuAddr;
  endfunction

  function automatic int onehotIdx(input logic [NUM_EXT-1:0] v);
    for (int i = 0; i < NUM_EXT; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int logAt(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s at t=%0t: observed %0h expected %0h", tag, $time, observed, expected);
    end
  endtask

  task automatic checkAllOutputs();
    int ph, cy;
    logic [NUM_EXT-1:0] aR, aF, dR, dF;
    ph = mT % 4;
    cy = (mT / 4) % 4;
    aR = expAck(mValid, mIdx);
    aF = expAck(fValid, fIdx);
    dR = (ph == 3) ? aR : '0;
    dF = (ph == 3) ? aF : '0;
    checkOutput("busCycle", 32'(rrCycle), 32'(cy));
    checkOutput("enables", {29'd0, rrEnP, rrEnN, rrLatch}, {29'd0, ph == 3, ph == 1, ph == 3});
    checkOutput("owners", {29'd0, rrVideo, rrCpu, rrExtra}, {29'd0, cy == 0, cy == 1 || cy == 3, cy == 2});
    checkOutput("rrAck", 32'(rrAck), 32'(aR));
    checkOutput("rrDone", 32'(rrDone), 32'(dR));
    checkOutput("rrIdx", 32'(rrIdx), 32'(mIdx));
    checkOutput("rrAddr", 32'(rrAddr), 32'(expAddr(aR, mIdx)));
    checkOutput("fxCycle", 32'(fxCycle), 32'(cy));
    checkOutput("fxAck", 32'(fxAck), 32'(aF));
    checkOutput("fxDone", 32'(fxDone), 32'(dF));
    checkOutput("fxIdx", 32'(fxIdx), 32'(fIdx));
    checkOutput("fxAddr", 32'(fxAddr), 32'(expAddr(aF, fIdx)));
    if (rrDone != 0) rrLog.push_back(onehotIdx(rrDone));
    if (fxDone != 0) fxLog.push_back(onehotIdx(fxDone));
    // Clients behave as specified: hold req until their done pulse.
    pending = pending & ~dR;
  endtask

  task automatic driveInputs(input logic [NUM_EXT-1:0] pattern);
    extReq    = pattern;
    cpuAddr   = ADDR_W'($urandom);
    videoAddr = ADDR_W'($urandom);
    for (int i = 0; i < NUM_EXT; i++) extAddrArr[i] = ADDR_W'($urandom);
  endtask

  task automatic applyStimulus(input logic [NUM_EXT-1:0] pattern, input int nCycles);
    for (int i = 0; i < nCycles; i++) begin
      @(negedge clk);
      checkAllOutputs();
      driveInputs(pattern);
    end
  endtask

  task automatic applyUntilDone(input logic [NUM_EXT-1:0] pattern);
    int startSize, n;
    startSize = rrLog.size();
    n = 0;
    while (rrLog.size() == startSize && n < 64) begin
      applyStimulus(pattern, 1);
      n++;
    end
    if (rrLog.size() == startSize) checkOutput("doneTimeout", 32'd1, 32'd0);
  endtask

  task automatic applyRandomClients(input int nCycles);
    for (int i = 0; i < nCycles; i++) begin
      @(negedge clk);
      checkAllOutputs();
      for (int c = 0; c < NUM_EXT; c++) begin
        if (!pending[c] && $urandom_range(7, 0) == 0) pending[c] = 1'b1;
      end
      driveInputs(pending);
    end
  endtask

  initial begin
    for (int i = 0; i < NUM_EXT; i++) extAddrArr[i] = '0;

    // Reset state, then idle: plain video/CPU pattern, fixed rotation runs alone.
    applyStimulus('0, 3);
    rstN = 1'b1;
    fxLog.delete();
    applyStimulus('0, 64);
    checkOutput("fxIdleCount", 32'(fxLog.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++) checkOutput("fxIdleOrder", 32'(logAt(fxLog, i)), 32'(i));
    checkOutput("rrIdleDone", 32'(rrLog.size()), 32'd0);

    // All clients requesting: plain rotation starting at client 0.
    rrLog.delete();
    applyStimulus('1, 80);
    checkOutput("rrFullCount", 32'(rrLog.size() >= 5), 32'd1);
    for (int i = 0; i < 5; i++) checkOutput("rrFullOrder", 32'(logAt(rrLog, i)), 32'(i % NUM_EXT));
    applyStimulus('0, 16);

    // Sparse requesters: idle clients are skipped.
    rrLog.delete();
    applyUntilDone(4'b0100);
    applyUntilDone(4'b1001);
    applyUntilDone(4'b0001);
    checkOutput("rrSkipCount", 32'(rrLog.size()), 32'd3);
    checkOutput("rrSkip0", 32'(logAt(rrLog, 0)), 32'd2);
    checkOutput("rrSkip1", 32'(logAt(rrLog, 1)), 32'd3);
    checkOutput("rrSkip2", 32'(logAt(rrLog, 2)), 32'd0);

    // Request dropped right after the decision edge still completes once.
    rrLog.delete();
    applyStimulus(4'b0010, 1);
    for (int n = 0; n < 32 && (mT % 16) != 8; n++) applyStimulus(4'b0010, 1);
    applyStimulus('0, 32);
    checkOutput("dropCount", 32'(rrLog.size()), 32'd1);
    checkOutput("dropIdx", 32'(logAt(rrLog, 0)), 32'd1);

    // Randomised clients that hold req until done.
    pending = '0;
    applyRandomClients(2000);
    pending = '0;
    applyStimulus('0, 32);

    // Asynchronous reset in the middle of an acknowledged extra cycle.
    rrLog.delete();
    applyStimulus(4'b0010, 1);
    for (int n = 0; n < 64 && !((mT % 16) == 9 && expAck(mValid, mIdx) != 0); n++) begin
      applyStimulus(4'b0010, 1);
    end
    checkOutput("abortSetup", 32'(rrAck), 32'h2);
    #2 rstN = 1'b0;
    #1 checkAllOutputs();
    checkOutput("abortAck", 32'(rrAck), 32'd0);
    applyStimulus('0, 2);
    rstN = 1'b1;
    applyUntilDone('1);
    checkOutput("abortCount", 32'(rrLog.size()), 32'd1);
    checkOutput("abortFirst", 32'(logAt(rrLog, 0)), 32'd0);
    applyStimulus('0, 8);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
